xorl_arb: RTL
=============

XORL_ARB -- requirements
Module: xorl_arb

Interface
REQ-001 Parameter: W, default 8, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0, req1  input  1 each  request from requester 0/1; held high until the matching grant pulse.
REQ-005 Port: a0, b0, a1, b1  input  W each  operands of requester 0/1; stable while the matching req is high.
REQ-006 Port: gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured on the same edge.
REQ-007 Port: y  output  W  registered result a^b of the granted request.
REQ-008 Port: vld  output  1  y/id valid; held until acknowledged.
REQ-009 Port: id  output  1  requester index owning y.
REQ-010 Port: ack  input  1  consumer accepts y; sampled only in DONE.
REQ-011 Port: cnt0, cnt1  output  8 each  per-requester grant counters (see Configuration).

Function
REQ-012 The block shall instantiate one xorl (bitwise XOR, W bits) as the shared datapath, fed from internal operand registers a_r/b_r.
REQ-013 The FSM shall have states IDLE, EXEC, DONE.
REQ-014 IDLE: with no request, remain in IDLE with all outputs held.
REQ-015 IDLE with a request present: at the edge, capture the winner's operands into a_r/b_r, set id_r to the winner, pulse the winner's gnt high for exactly one cycle, and go to EXEC.
REQ-016 Arbitration shall be round-robin with a 1-bit pointer ptr.
REQ-017 With both requests present, the winner shall be the requester indexed by ptr.
REQ-018 With a single request present, that requester shall win regardless of ptr.
REQ-019 After every grant, ptr shall be set to the loser index (i.e. ~winner).
REQ-020 EXEC: at the edge, load y with the xorl output, drive id from id_r, set vld=1, and go to DONE.
REQ-021 DONE: hold y, id and vld=1 while ack=0.
REQ-022 DONE with ack=1 at an edge: clear vld and go to IDLE; y and id shall keep their last value.
REQ-023 ack in IDLE or EXEC shall be ignored.
REQ-024 Latency: request sampled in IDLE -> gnt after 1 edge -> vld after 2 edges; minimum transaction time 3 cycles with ack tied high.
REQ-025 A req deasserted before its grant is withdrawn, with no side effects.
REQ-026 A req still high in the IDLE cycle after its grant shall be treated as a new request.
REQ-027 Requests arriving in EXEC or DONE shall wait and shall never be lost or reordered within a requester.
REQ-028 gnt0 and gnt1 shall never be high in the same cycle.
REQ-029 At most one transaction shall be in flight.

Reset
REQ-030 On rst high, immediately and independent of clk: state=IDLE, ptr=0, gnt0=gnt1=0, vld=0, y=0, id=0, a_r=b_r=0, cnt0=cnt1=0.
REQ-031 Reset mid-transaction (EXEC or DONE) shall discard that transaction; after release the block shall restart from IDLE with requester 0 prioritised.

Configuration
REQ-032 The macro XORL_ARB_CNT_EN shall control the grant counters.
REQ-033 When XORL_ARB_CNT_EN is defined, cnt0/cnt1 shall increment by 1 on each gnt0/gnt1 pulse, modulo 256 (255 -> 0).
REQ-034 When XORL_ARB_CNT_EN is undefined, cnt0/cnt1 shall be constant 0 and no counter registers shall be synthesised; all other behaviour shall be identical.

Verification
REQ-035 Single request: req0=1, a0=8'hF0, b0=8'h00, ack=1 -> gnt0 pulse at edge 1; y=8'hF0, id=0, vld=1 at edge 2; vld=0 at edge 3.
REQ-036 Contention after reset: req0=req1=1, a0=F0/b0=FF, a1=F0/b1=AA, each req dropped after its gnt -> first y=8'h0F with id=0, then y=8'h5A with id=1; gnt never simultaneous.
REQ-037 Fairness: req0 and req1 held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-038 Backpressure: ack=0 for 5 cycles in DONE -> y, id and vld=1 stable, no new gnt; ack=1 -> vld=0 next edge, next grant on the following edge.
REQ-039 Reset mid-op: assert rst during EXEC -> vld=0, y=0, gnt=0 immediately (asynchronous); no vld until a new request arrives.
REQ-040 With XORL_ARB_CNT_EN defined, 257 requester-0 transactions -> cnt0=8'h01, cnt1=8'h00; with the macro undefined, both counters stay 0.

Source files
------------

// File: rtl/xorl_arb.sv
// Two-requester round-robin arbiter sharing one registered XOR datapath.
// Define XORL_ARB_CNT_EN to build the per-requester grant counters.

module xorl #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a ^ b;
endmodule

module xorl_arb #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic [W-1:0] y,
    output logic         vld,
    output logic         id,
    input  logic         ack,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t         state;
    state_t         state_next;
    logic           ptr;
    logic           take;
    logic           win;
    logic           id_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic [W-1:0]   x_out;

    xorl #(.W(W)) u_xorl (
        .a (a_r),
        .b (b_r),
        .y (x_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Single request wins outright; contention is settled by ptr.
    always_comb begin
        state_next = state;
        take       = 1'b0;
        win        = ptr;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    take       = 1'b1;
                    win        = (req0 && req1) ? ptr : req1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = DONE;
            DONE:    if (ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr  <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            a_r  <= '0;
            b_r  <= '0;
            id_r <= 1'b0;
            y    <= '0;
            id   <= 1'b0;
            vld  <= 1'b0;
        end else begin
            gnt0 <= take && !win;
            gnt1 <= take && win;
            if (take) begin
                a_r  <= win ? a1 : a0;
                b_r  <= win ? b1 : b0;
                id_r <= win;
                ptr  <= ~win;
            end
            if (state == EXEC) begin
                y   <= x_out;
                id  <= id_r;
                vld <= 1'b1;
            end
            if (state == DONE && ack) vld <= 1'b0;
        end
    end

`ifdef XORL_ARB_CNT_EN
    logic [7:0] cnt0_r;
    logic [7:0] cnt1_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_r <= '0;
            cnt1_r <= '0;
        end else if (take) begin
            if (win) cnt1_r <= cnt1_r + 8'd1;
            else     cnt0_r <= cnt0_r + 8'd1;
        end
    end

    assign cnt0 = cnt0_r;
    assign cnt1 = cnt1_r;
`else
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule
